// File: rtl/dsss_frame_modulator_if.sv
// Byte-in / sample-out stream bundle for dsss_frame_modulator.
// slave = modulator side, master = the source/sink driving it.
interface dsss_frame_modulator_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] i_data;
  logic              i_valid_input;
  logic              o_ready;
  logic [31:0]       o_data;
  logic              o_valid_output;

  modport master (
    output i_data,
    output i_valid_input,
    input  o_ready,
    input  o_data,
    input  o_valid_output
  );

  modport slave (
    input  i_data,
    input  i_valid_input,
    output o_ready,
    output o_data,
    output o_valid_output
  );
endinterface

// File: rtl/dsss_frame_modulator.sv
// Frame-based DSSS BPSK modulator.
// Payload bytes fill one bank of a ping-pong pair while the other bank is
// spread and sent. Every frame is the fixed preamble followed by the payload.
// If no full payload bank is ready at a frame boundary, a blank frame
// (preamble + zeros) is sent so the sample stream never stalls.
module dsss_frame_modulator #(
  parameter int                       SIZE_INPUT_BIT   = 8,
  parameter int                       SIZE_BIT_PACK    = 1976,
  parameter int                       SIZE_PREAMBLE    = 32,
  parameter logic [SIZE_PREAMBLE-1:0] PREAMBLE         = 32'h1ACFFC1D,
  parameter int                       CHIPS_PER_BIT    = 240,
  parameter int                       SAMPLES_PER_CHIP = 2,
  parameter int                       AMPLITUDE        = 8191
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  dsss_frame_modulator_if.slave  bus
);

  localparam int NBYTES    = SIZE_BIT_PACK / 8;
  localparam int PRE_BYTES = SIZE_PREAMBLE / 8;
  localparam int PAY_BYTES = NBYTES - PRE_BYTES;
  localparam int SW        = (SAMPLES_PER_CHIP > 1) ? $clog2(SAMPLES_PER_CHIP) : 1;
  localparam int CW        = (CHIPS_PER_BIT > 1) ? $clog2(CHIPS_PER_BIT) : 1;
  localparam int BW        = $clog2(SIZE_BIT_PACK);
  localparam int PAW       = (PAY_BYTES > 1) ? $clog2(PAY_BYTES) : 1;
  localparam int WPW       = $clog2(NBYTES + 1);

  localparam logic [7:0]  SEED_I  = 8'hFF;
  localparam logic [7:0]  SEED_Q  = 8'h5A;
  localparam logic [15:0] POS_AMP = 16'(AMPLITUDE);
  localparam logic [15:0] NEG_AMP = 16'(-AMPLITUDE);

  // ST_WAKE is the single idle cycle after reset release; the sample
  // pipeline starts counting on the cycle after it.
  typedef enum logic {
    ST_WAKE,
    ST_RUN
  } state_t;

  state_t state_q, state_d;

  logic [SW-1:0]  smp_q, smp_d;
  logic [CW-1:0]  chip_q, chip_d;
  logic [BW-1:0]  bit_q, bit_d;
  logic [7:0]     pn_i_q, pn_i_d;
  logic [7:0]     pn_q_q, pn_q_d;
  logic           tx_sel_q, tx_sel_d;
  logic [WPW-1:0] wptr_q, wptr_d;
  logic [SIZE_INPUT_BIT-1:0] bank_q [2][PAY_BYTES];
  logic [SIZE_INPUT_BIT-1:0] bank_d [2][PAY_BYTES];
  logic [31:0]    data_q, data_d;
  logic           valid_q, valid_d;

  logic running;
  logic last_smp, last_chip, last_bit, frame_end;
  logic fill_full, ready, accept;
  logic [PAW-1:0] wr_idx, pay_idx;
  logic [SIZE_PREAMBLE-1:0]  pre_sh;
  logic [SIZE_INPUT_BIT-1:0] pay_byte, pay_sh;
  logic frame_bit, ci_bit, cq_bit;

  // Fibonacci LFSR x^8+x^6+x^5+x^4+1, shifting toward bit 0 (the output).
  function automatic logic [7:0] lfsr_step(input logic [7:0] s);
    return {s[0] ^ s[2] ^ s[3] ^ s[4], s[7:1]};
  endfunction

  assign running   = (state_q == ST_RUN);
  assign last_smp  = (smp_q == SW'(SAMPLES_PER_CHIP - 1));
  assign last_chip = (chip_q == CW'(CHIPS_PER_BIT - 1));
  assign last_bit  = (bit_q == BW'(SIZE_BIT_PACK - 1));
  assign frame_end = running && last_smp && last_chip && last_bit;
  assign fill_full = (wptr_q == WPW'(NBYTES));
  assign ready     = running && (wptr_q < WPW'(NBYTES));
  assign accept    = bus.i_valid_input && ready;
  assign wr_idx    = PAW'(wptr_q - WPW'(PRE_BYTES));

  assign bus.o_ready        = ready;
  assign bus.o_data         = data_q;
  assign bus.o_valid_output = valid_q;

  // Wake-up sequencing: leave ST_WAKE after one cycle, then run forever.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_WAKE: state_d = ST_RUN;
      ST_RUN:  state_d = ST_RUN;
      default: state_d = ST_WAKE;
    endcase
  end

  // State register.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) state_q <= ST_WAKE;
    else         state_q <= state_d;
  end

  // Sample/chip/bit counters and PN generators; both LFSRs reseed per bit.
  always_comb begin
    smp_d  = smp_q;
    chip_d = chip_q;
    bit_d  = bit_q;
    pn_i_d = pn_i_q;
    pn_q_d = pn_q_q;
    if (running) begin
      if (last_smp) begin
        smp_d = '0;
        if (last_chip) begin
          chip_d = '0;
          pn_i_d = SEED_I;
          pn_q_d = SEED_Q;
          bit_d  = last_bit ? '0 : bit_q + 1'b1;
        end else begin
          chip_d = chip_q + 1'b1;
          pn_i_d = lfsr_step(pn_i_q);
          pn_q_d = lfsr_step(pn_q_q);
        end
      end else begin
        smp_d = smp_q + 1'b1;
      end
    end
  end

  // Current frame bit (MSB first): preamble constant, then TX-bank payload.
  always_comb begin
    pre_sh  = PREAMBLE << bit_q;
    pay_idx = '0;
    if (bit_q >= BW'(SIZE_PREAMBLE)) begin
      pay_idx = PAW'((bit_q >> 3) - BW'(PRE_BYTES));
    end
    pay_byte  = bank_q[tx_sel_q][pay_idx];
    pay_sh    = pay_byte << bit_q[2:0];
    frame_bit = (bit_q < BW'(SIZE_PREAMBLE)) ? pre_sh[SIZE_PREAMBLE-1]
                                              : pay_sh[SIZE_INPUT_BIT-1];
  end

  // BPSK mapping of the spread chips to the registered I/Q sample.
  always_comb begin
    ci_bit  = frame_bit ^ pn_i_q[0];
    cq_bit  = frame_bit ^ pn_q_q[0];
    valid_d = running;
    data_d  = '0;
    if (running) begin
      data_d = {ci_bit ? NEG_AMP : POS_AMP, cq_bit ? NEG_AMP : POS_AMP};
    end
  end

  // Ping-pong bank management. At a frame boundary the bank just sent is
  // always cleared: on a swap it becomes the new (empty) fill bank, without
  // a swap it is re-sent as the blank frame. The fill bank is never touched
  // by the clear, so a concurrent byte write cannot collide with it.
  always_comb begin
    bank_d   = bank_q;
    wptr_d   = wptr_q;
    tx_sel_d = tx_sel_q;
    if (accept) begin
      bank_d[~tx_sel_q][wr_idx] = bus.i_data;
      wptr_d = wptr_q + 1'b1;
    end
    if (frame_end) begin
      for (int unsigned i = 0; i < PAY_BYTES; i++) begin
        bank_d[tx_sel_q][PAW'(i)] = '0;
      end
      if (fill_full) begin
        tx_sel_d = ~tx_sel_q;
        wptr_d   = WPW'(PRE_BYTES);
      end
    end
  end

  // Datapath registers.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      smp_q    <= '0;
      chip_q   <= '0;
      bit_q    <= '0;
      pn_i_q   <= SEED_I;
      pn_q_q   <= SEED_Q;
      tx_sel_q <= 1'b0;
      wptr_q   <= WPW'(PRE_BYTES);
      bank_q   <= '{default: '0};
      data_q   <= '0;
      valid_q  <= 1'b0;
    end else begin
      smp_q    <= smp_d;
      chip_q   <= chip_d;
      bit_q    <= bit_d;
      pn_i_q   <= pn_i_d;
      pn_q_q   <= pn_q_d;
      tx_sel_q <= tx_sel_d;
      wptr_q   <= wptr_d;
      bank_q   <= bank_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
    end
  end

endmodule

// File: tb/tb_dsss_frame_modulator.sv
// Scoreboard bench for dsss_frame_modulator, run on a shortened frame
// (64-bit frame, 4 payload bytes, 16 chips/bit, 2 samples/chip).
// PN chip tables below are worked out by hand from the seeds and polynomial;
// bit k of each table is chip k of every frame bit.
module tb_dsss_frame_modulator;

  localparam int          NBITS = 64;
  localparam int          CPB   = 16;
  localparam int          SPC   = 2;
  localparam int          FRAME = NBITS * CPB * SPC;
  localparam logic [31:0] PRE   = 32'h1ACFFC1D;
  localparam logic [15:0] PN_I  = 16'hD0FF;
  localparam logic [15:0] PN_Q  = 16'hA25A;
  localparam logic [15:0] POS   = 16'h1FFF;
  localparam logic [15:0] NEG   = 16'hE001;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dsss_frame_modulator_if #(.DATA_W(8)) bus ();

  dsss_frame_modulator #(
    .SIZE_INPUT_BIT  (8),
    .SIZE_BIT_PACK   (NBITS),
    .SIZE_PREAMBLE   (32),
    .PREAMBLE        (PRE),
    .CHIPS_PER_BIT   (CPB),
    .SAMPLES_PER_CHIP(SPC),
    .AMPLITUDE       (8191)
  ) dut (
    .i_clk  (clk),
    .i_reset(rst),
    .bus    (bus)
  );

  int          checks     = 0;
  int          passes     = 0;
  int          sample_cnt = 0;
  bit          seen_valid = 1'b0;
  logic [31:0] exp_q[$];

  function automatic void chk(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
  endfunction

  // Expected samples for one frame: preamble then 4 payload bytes MSB first.
  task automatic push_frame(input logic [31:0] pay);
    logic [63:0] fr;
    logic [15:0] pi, pq;
    logic        b;
    fr = {PRE, pay};
    pi = PN_I;
    pq = PN_Q;
    for (int n = 0; n < NBITS; n++) begin
      b = fr[NBITS-1-n];
      for (int k = 0; k < CPB; k++) begin
        for (int s = 0; s < SPC; s++) begin
          exp_q.push_back({(b ^ pi[k]) ? NEG : POS, (b ^ pq[k]) ? NEG : POS});
        end
      end
    end
  endtask

  task automatic wait_samples(input int target);
    int budget;
    budget = 4 * FRAME;
    while (sample_cnt < target && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    if (sample_cnt < target) begin
      checks++;
      $display("FAIL wait_samples: reached %0d, want %0d", sample_cnt, target);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    bus.i_data        = b;
    bus.i_valid_input = 1'b1;
    @(negedge clk);
    bus.i_valid_input = 1'b0;
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("wake_valid", 32'(bus.o_valid_output), 32'd0);
    @(posedge clk);
    #1;
    chk("first_valid", 32'(bus.o_valid_output), 32'd1);
    chk("first_sample", bus.o_data, {NEG, POS});
    chk("ready_after_reset", 32'(bus.o_ready), 32'd1);
  endtask

  // Monitor: pops one expected sample per valid output sample.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        sample_cnt = 0;
        seen_valid = 1'b0;
      end else begin
        if (seen_valid) chk("valid_continuous", 32'(bus.o_valid_output), 32'd1);
        if (bus.o_valid_output) begin
          seen_valid = 1'b1;
          if (exp_q.size() == 0) begin
            checks++;
            $display("FAIL sample_underflow: got %h, want no sample (t=%0t)",
                     bus.o_data, $time);
          end else begin
            chk($sformatf("sample_%0d", sample_cnt), bus.o_data, exp_q.pop_front());
          end
          sample_cnt++;
        end
      end
    end
  end

  // Stimulus.
  initial begin
    bus.i_data        = '0;
    bus.i_valid_input = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_valid", 32'(bus.o_valid_output), 32'd0);
    chk("rst_ready", 32'(bus.o_ready), 32'd0);
    chk("rst_data", bus.o_data, 32'd0);

    // frame 0 blank; fill a full bank of FF during it
    push_frame(32'h0000_0000);
    release_reset();
    wait_samples(100);
    for (int i = 0; i < 4; i++) begin
      chk("ready_before_byte", 32'(bus.o_ready), 32'd1);
      send_byte(8'hFF);
    end
    chk("ready_low_when_full", 32'(bus.o_ready), 32'd0);
    send_byte(8'h00);
    chk("ready_stays_low", 32'(bus.o_ready), 32'd0);
    send_byte(8'h00);
    push_frame(32'hFFFF_FFFF);

    // frame 1 carries FF; ready back after the swap; frame 2 blank
    wait_samples(FRAME + 10);
    chk("ready_after_swap", 32'(bus.o_ready), 32'd1);
    push_frame(32'h0000_0000);

    // partial fill during frame 2 -> frame 3 still blank
    wait_samples(2 * FRAME + 100);
    send_byte(8'hA5);
    send_byte(8'h3C);
    chk("ready_partial", 32'(bus.o_ready), 32'd1);
    push_frame(32'h0000_0000);

    // complete during frame 3, extra writes dropped -> frame 4 carries data
    wait_samples(3 * FRAME + 100);
    send_byte(8'h81);
    send_byte(8'h7E);
    chk("ready_low_completed", 32'(bus.o_ready), 32'd0);
    send_byte(8'h00);
    send_byte(8'hFF);
    chk("ready_low_dropped", 32'(bus.o_ready), 32'd0);
    push_frame(32'hA53C_817E);

    wait_samples(4 * FRAME + 10);
    chk("ready_after_swap2", 32'(bus.o_ready), 32'd1);
    push_frame(32'h0000_0000);

    // fill during frame 5, then reset mid-frame: data must be discarded
    wait_samples(5 * FRAME + 100);
    for (int i = 0; i < 4; i++) send_byte(8'h55);
    chk("ready_low_before_reset", 32'(bus.o_ready), 32'd0);
    wait_samples(5 * FRAME + 1000);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_valid", 32'(bus.o_valid_output), 32'd0);
    chk("midrst_data", bus.o_data, 32'd0);
    chk("midrst_ready", 32'(bus.o_ready), 32'd0);
    exp_q.delete();
    repeat (3) push_frame(32'h0000_0000);
    repeat (4) @(negedge clk);
    release_reset();
    wait_samples(2 * FRAME);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
